// File: rtl/cmos_pkg.sv
// Shared types and constants for the CMOS sensor configuration path.
package cmos_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PWR,
      ST_FETCH,
      ST_START,
      ST_SHIFT,
      ST_STOP,
      ST_GAP,
      ST_SRST,
      ST_DONE
   } sccb_state_e;

   // One register-table word as delivered by the ROM.
   typedef struct packed {
      logic [7:0] reg_addr;
      logic [7:0] val;
   } sccb_entry_t;

   localparam logic [7:0]  COM7_ADDR      = 8'h12;
   localparam int unsigned SCCB_FRAME_LEN = 27;
   localparam int unsigned SCCB_BIT_W     = 5;
   localparam int unsigned TBL_ADDR_W     = 10;
   localparam logic [7:0]  DEF_DEV_ADDR   = 8'h60;

   // The don't-care 9th bit of each phase sits at frame indices 18, 9 and 0.
   function automatic logic is_ack_bit(input logic [SCCB_BIT_W-1:0] bit_idx);
      return (bit_idx == 5'd18) || (bit_idx == 5'd9) || (bit_idx == 5'd0);
   endfunction

   function automatic logic [SCCB_FRAME_LEN-1:0] build_frame(input logic [7:0] dev,
                                                            input sccb_entry_t ent);
      return {dev, 1'b1, ent.reg_addr, 1'b1, ent.val, 1'b1};
   endfunction

endpackage

// File: rtl/sccb_quarter_tick.sv
// Quarter-bit strobe generator for the SCCB sequencer; held at zero while
// disabled so every enabled stretch starts on a clean quarter boundary.
module sccb_quarter_tick #(
   parameter int unsigned CLK_DIV = 60
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick_c,
   output logic mid_c
);

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(CLK_DIV / 2);

   logic [CNT_W-1:0] cnt_q;

   assign tick_c = en && (cnt_q == CNT_MAX);
   assign mid_c  = en && (cnt_q == CNT_MID);

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt_q <= '0;
      end else if (tick_c) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sccb_cfg_ctrl.sv
// SCCB register-table sequencer: power-up settle, one 3-phase write per ROM
// entry, COM7 soft-reset settle, completion pulse. NACK checking: SCCB_ACK_CHECK_EN.
module sccb_cfg_ctrl
   import cmos_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 60,
   parameter int unsigned TABLE_LEN = 192,
   parameter logic [7:0]  DEV_ADDR  = DEF_DEV_ADDR,
   parameter int unsigned PWR_WAIT  = 96000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [TBL_ADDR_W-1:0] tbl_addr,
   input  logic [15:0]           tbl_data,
   output logic                  sio_c,
   output logic                  sio_d_out,
   output logic                  sio_d_oe,
   input  logic                  sio_d_in
);

   localparam int unsigned WAIT_W = $clog2(PWR_WAIT + 1);
   localparam logic [TBL_ADDR_W-1:0] LAST_ADDR = TBL_ADDR_W'(TABLE_LEN - 1);

   sccb_state_e                 state_q, state_d;
   logic [WAIT_W-1:0]           wait_q, wait_d;
   logic [TBL_ADDR_W-1:0]       addr_q, addr_d;
   logic [SCCB_FRAME_LEN-1:0]   frame_q, frame_d;
   logic [1:0]                  qtr_q, qtr_d;
   logic [SCCB_BIT_W-1:0]       bit_q, bit_d;
   logic                        srst_q, srst_d;
   logic                        last_q, last_d;
   logic                        err_q, err_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic                        sio_c_q, sio_c_d;
   logic                        sio_d_q, sio_d_d;
   logic                        sio_oe_q, sio_oe_d;
   logic                        qen_c, tick_c, mid_c;
   sccb_entry_t                 ent_c;

   assign ent_c = sccb_entry_t'(tbl_data);
   assign qen_c = state_q inside {ST_START, ST_SHIFT, ST_STOP, ST_GAP};

   sccb_quarter_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .en     (qen_c),
      .tick_c (tick_c),
      .mid_c  (mid_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         wait_q   <= '0;
         addr_q   <= '0;
         frame_q  <= '0;
         qtr_q    <= '0;
         bit_q    <= '0;
         srst_q   <= 1'b0;
         last_q   <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sio_c_q  <= 1'b1;
         sio_d_q  <= 1'b1;
         sio_oe_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         addr_q   <= addr_d;
         frame_q  <= frame_d;
         qtr_q    <= qtr_d;
         bit_q    <= bit_d;
         srst_q   <= srst_d;
         last_q   <= last_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         sio_c_q  <= sio_c_d;
         sio_d_q  <= sio_d_d;
         sio_oe_q <= sio_oe_d;
      end
   end

   // Next state. The table index advances on entry to GAP so the synchronous
   // ROM has the whole gap to present the next word before FETCH latches it.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      addr_d  = addr_q;
      frame_d = frame_q;
      qtr_d   = qtr_q;
      bit_d   = bit_q;
      srst_d  = srst_q;
      last_d  = last_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_PWR;
               wait_d  = WAIT_W'(PWR_WAIT);
               addr_d  = '0;
               err_d   = 1'b0;
            end
         end
         ST_PWR, ST_SRST: begin
            if (wait_q == '0) begin
               state_d = (state_q == ST_SRST && last_q) ? ST_DONE : ST_FETCH;
            end else begin
               wait_d = wait_q - WAIT_W'(1);
            end
         end
         ST_FETCH: begin
            frame_d = build_frame(DEV_ADDR, ent_c);
            srst_d  = (ent_c.reg_addr == COM7_ADDR) && ent_c.val[7];
            last_d  = (addr_q == LAST_ADDR);
            qtr_d   = '0;
            state_d = ST_START;
         end
         ST_START: begin
            if (tick_c) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd1) begin
                  state_d = ST_SHIFT;
                  qtr_d   = '0;
                  bit_d   = SCCB_BIT_W'(SCCB_FRAME_LEN - 1);
               end
            end
         end
         ST_SHIFT: begin
            if (tick_c) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd3) begin
                  if (bit_q == '0) begin
                     state_d = ST_STOP;
                  end else begin
                     bit_d = bit_q - SCCB_BIT_W'(1);
                  end
               end
            end
         end
         ST_STOP: begin
            if (tick_c) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd2) begin
                  state_d = ST_GAP;
                  qtr_d   = '0;
                  if (!last_q) begin
                     addr_d = addr_q + TBL_ADDR_W'(1);
                  end
               end
            end
         end
         ST_GAP: begin
            if (tick_c) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd3) begin
                  if (srst_q) begin
                     state_d = ST_SRST;
                     wait_d  = WAIT_W'(PWR_WAIT - 1);
                  end else if (last_q) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_FETCH;
                  end
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
`ifdef SCCB_ACK_CHECK_EN
      // Released 9th bit sampled mid-way through the high half of SIO_C.
      if (state_q == ST_SHIFT && qtr_q == 2'd2 && mid_c && is_ack_bit(bit_q) && sio_d_in) begin
         err_d = 1'b1;
      end
`else
      err_d = 1'b0;
`endif
   end

`ifndef SCCB_ACK_CHECK_EN
   logic unused_c;
   assign unused_c = ^{sio_d_in, mid_c, err_q};
`endif

   // Output values for the coming cycle, registered alongside the state.
   always_comb begin
      busy_d   = !(state_d inside {ST_IDLE, ST_DONE});
      done_d   = (state_d == ST_DONE);
      sio_c_d  = 1'b1;
      sio_d_d  = 1'b1;
      sio_oe_d = 1'b1;
      case (state_d)
         ST_START: begin
            sio_d_d = 1'b0;
         end
         ST_SHIFT: begin
            sio_c_d  = qtr_d[1];
            sio_d_d  = frame_d[bit_d];
            sio_oe_d = !is_ack_bit(bit_d);
         end
         ST_STOP: begin
            sio_c_d = (qtr_d != 2'd0);
            sio_d_d = (qtr_d == 2'd2);
         end
         default: begin
            sio_c_d = 1'b1;
         end
      endcase
   end

   assign busy      = busy_q;
   assign done      = done_q;
`ifdef SCCB_ACK_CHECK_EN
   assign err       = err_q;
`else
   assign err       = 1'b0;
`endif
   assign tbl_addr  = addr_q;
   assign sio_c     = sio_c_q;
   assign sio_d_out = sio_d_q;
   assign sio_d_oe  = sio_oe_q;

endmodule

// File: tb/tb_sccb_cfg_ctrl.sv
// Directed bench for sccb_cfg_ctrl: timing checkpoints, SCCB bus decode,
// restart, ignored start, reset abort and (with SCCB_ACK_CHECK_EN) NACK flagging.
module tb_sccb_cfg_ctrl;

   localparam int unsigned CLK_DIV   = 4;
   localparam int unsigned PWR_WAIT  = 16;
   localparam int unsigned TABLE_LEN = 3;
   localparam int          NV        = 22;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, err, sio_c, sio_d_out, sio_d_oe, sio_d_in;
   logic [9:0]  tbl_addr;
   logic [15:0] tbl_data;
   logic [15:0] rom [3];
   logic        slave_drv = 1'b0;

   sccb_cfg_ctrl #(
      .CLK_DIV   (CLK_DIV),
      .TABLE_LEN (TABLE_LEN),
      .DEV_ADDR  (8'h60),
      .PWR_WAIT  (PWR_WAIT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .tbl_addr  (tbl_addr),
      .tbl_data  (tbl_data),
      .sio_c     (sio_c),
      .sio_d_out (sio_d_out),
      .sio_d_oe  (sio_d_oe),
      .sio_d_in  (sio_d_in)
   );

   always #5 clk = ~clk;

   always @(posedge clk) tbl_data <= (tbl_addr < 10'd3) ? rom[tbl_addr[1:0]] : 16'h0000;

   assign sio_d_in = sio_d_oe ? sio_d_out : slave_drv;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Bus monitor: decodes START / 27 bits / STOP from the pad values.
   logic        prev_c = 1'b1, prev_d = 1'b1, in_frame = 1'b0;
   int          nbits = 0, cur_start = 0, max_addr = 0, nack_frame = -1;
   logic        nack_en = 1'b0;
   logic [26:0] sh = '0;
   logic [23:0] frm [$];
   int          frm_start [$];
   int          frm_stop [$];

   always @(negedge clk) begin
      if (rst) begin
         in_frame = 1'b0;
         nbits    = 0;
      end else if (prev_c && sio_c && prev_d && !sio_d_in) begin
         in_frame  = 1'b1;
         nbits     = 0;
         cur_start = cyc;
      end else if (in_frame && prev_c && sio_c && !prev_d && sio_d_in) begin
         if (nbits == 27) begin
            frm.push_back({sh[26:19], sh[17:10], sh[8:1]});
            frm_start.push_back(cur_start);
            frm_stop.push_back(cyc);
         end
         in_frame = 1'b0;
      end else if (in_frame && !prev_c && sio_c && nbits < 27) begin
         sh    = {sh[25:0], sio_d_in};
         nbits = nbits + 1;
      end
      if (!rst && int'(tbl_addr) > max_addr) max_addr = int'(tbl_addr);
      slave_drv = nack_en && in_frame && (frm.size() == nack_frame) && (nbits == 17 || nbits == 18);
      prev_c = sio_c;
      prev_d = sio_d_oe ? sio_d_out : slave_drv;
   end

   typedef struct {
      int         off;
      logic       busy;
      logic       done;
      logic       c;
      logic       d;
      logic       oe;
      logic [9:0] addr;
   } vec_t;

   vec_t        vecs [NV];
   logic [23:0] exp_frm [3];
   int          nvec = 0, nmis = 0, off = 0;

   function automatic vec_t mk(input int o, input logic b, input logic dn, input logic c,
                               input logic d, input logic oe, input logic [9:0] a);
      vec_t v;
      v.off = o; v.busy = b; v.done = dn; v.c = c; v.d = d; v.oe = oe; v.addr = a;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec = nvec + 1;
      if (act !== exp) begin
         nmis = nmis + 1;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic adv_to(input int t, input int inject);
      while (off < t) begin
         if (off == inject) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         off   = off + 1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      off   = 0;
   endtask

   task automatic chk_frames(input int base, input string tag);
      chk({tag, "_nframes"}, 32'(frm.size() - base), 32'd3);
      for (int j = 0; j < 3; j++) begin
         chk($sformatf("%s_frame%0d", tag, j), 32'(frm[base + j]), 32'(exp_frm[j]));
      end
   endtask

   task automatic run_table(input int inject, input string tag);
      int t0, base;
      base = frm.size();
      pulse_start();
      t0 = cyc;
      for (int i = 0; i < NV; i++) begin
         adv_to(vecs[i].off, inject);
         chk($sformatf("%s_busy@%0d", tag, off), 32'(busy), 32'(vecs[i].busy));
         chk($sformatf("%s_done@%0d", tag, off), 32'(done), 32'(vecs[i].done));
         chk($sformatf("%s_sioc@%0d", tag, off), 32'(sio_c), 32'(vecs[i].c));
         chk($sformatf("%s_siod@%0d", tag, off), 32'(sio_d_out), 32'(vecs[i].d));
         chk($sformatf("%s_oe@%0d", tag, off), 32'(sio_d_oe), 32'(vecs[i].oe));
         chk($sformatf("%s_addr@%0d", tag, off), 32'(tbl_addr), 32'(vecs[i].addr));
         chk($sformatf("%s_err@%0d", tag, off), 32'(err), 32'd0);
      end
      chk_frames(base, tag);
      chk({tag, "_first_fall"}, 32'(frm_start[base] - t0), 32'd18);
      chk({tag, "_gap_srst"}, 32'(frm_start[base + 1] - frm_stop[base]), 32'd37);
      chk({tag, "_gap_plain"}, 32'(frm_start[base + 2] - frm_stop[base + 1]), 32'd21);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rom[0] = 16'h1280; rom[1] = 16'hFF01; rom[2] = 16'h1101;
      exp_frm[0] = 24'h601280; exp_frm[1] = 24'h60FF01; exp_frm[2] = 24'h601101;
      vecs[0]  = mk(0,    1, 0, 1, 1, 1, 10'd0);
      vecs[1]  = mk(17,   1, 0, 1, 1, 1, 10'd0);
      vecs[2]  = mk(18,   1, 0, 1, 0, 1, 10'd0);
      vecs[3]  = mk(25,   1, 0, 1, 0, 1, 10'd0);
      vecs[4]  = mk(26,   1, 0, 0, 0, 1, 10'd0);
      vecs[5]  = mk(34,   1, 0, 1, 0, 1, 10'd0);
      vecs[6]  = mk(42,   1, 0, 0, 1, 1, 10'd0);
      vecs[7]  = mk(154,  1, 0, 0, 1, 0, 10'd0);
      vecs[8]  = mk(162,  1, 0, 1, 1, 0, 10'd0);
      vecs[9]  = mk(170,  1, 0, 0, 0, 1, 10'd0);
      vecs[10] = mk(458,  1, 0, 0, 0, 1, 10'd0);
      vecs[11] = mk(462,  1, 0, 1, 0, 1, 10'd0);
      vecs[12] = mk(466,  1, 0, 1, 1, 1, 10'd0);
      vecs[13] = mk(469,  1, 0, 1, 1, 1, 10'd0);
      vecs[14] = mk(470,  1, 0, 1, 1, 1, 10'd1);
      vecs[15] = mk(486,  1, 0, 1, 1, 1, 10'd1);
      vecs[16] = mk(502,  1, 0, 1, 1, 1, 10'd1);
      vecs[17] = mk(503,  1, 0, 1, 0, 1, 10'd1);
      vecs[18] = mk(955,  1, 0, 1, 1, 1, 10'd2);
      vecs[19] = mk(1439, 1, 0, 1, 1, 1, 10'd2);
      vecs[20] = mk(1440, 0, 1, 1, 1, 1, 10'd2);
      vecs[21] = mk(1441, 0, 0, 1, 1, 1, 10'd2);

      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_addr", 32'(tbl_addr), 32'd0);
      chk("rst_sioc", 32'(sio_c), 32'd1);
      chk("rst_siod", 32'(sio_d_out), 32'd1);
      chk("rst_oe", 32'(sio_d_oe), 32'd1);
      rst = 1'b0;
      @(negedge clk);

      run_table(-1, "run1");
      run_table(100, "run2");

`ifdef SCCB_ACK_CHECK_EN
      base       = frm.size();
      nack_frame = base + 1;
      nack_en    = 1'b1;
      pulse_start();
      adv_to(793, -1);
      chk("nack_err_before", 32'(err), 32'd0);
      adv_to(794, -1);
      chk("nack_err_set", 32'(err), 32'd1);
      adv_to(1440, -1);
      chk("nack_done", 32'(done), 32'd1);
      chk("nack_err_at_done", 32'(err), 32'd1);
      nack_en = 1'b0;
      chk_frames(base, "nack");
      adv_to(1441, -1);
      chk("nack_err_idle", 32'(err), 32'd1);
      pulse_start();
      chk("nack_err_cleared", 32'(err), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
`else
      base = frm.size();
      chk("no_extra_frames", 32'(base), 32'd6);
`endif

      pulse_start();
      adv_to(600, -1);
      chk("abort_pre_busy", 32'(busy), 32'd1);
      chk("abort_pre_addr", 32'(tbl_addr), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_sioc", 32'(sio_c), 32'd1);
      chk("abort_siod", 32'(sio_d_out), 32'd1);
      chk("abort_oe", 32'(sio_d_oe), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_addr", 32'(tbl_addr), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      chk("max_tbl_addr", 32'(max_addr), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/sccb_cfg_ctrl.md
# sccb_cfg_ctrl

Sequencer that configures the CMOS image sensor over SCCB after power-up. It walks a register table of `{reg, val}` words and issues one 3-phase SCCB write per entry. It inserts a settle delay after power-up and after a soft-reset write, and reports completion so the capture path (`cmos_ctrl`) can be released. It sits beside `clock_gene` in the top level and drives the sensor's SIO_C/SIO_D pins; the top level builds the open-drain pad from `sio_d_oe`/`sio_d_out`.

## Interface
Parameters:
- `CLK_DIV`, 60: clk cycles per SCCB quarter-bit. Bit period is 4·CLK_DIV; 60 at 96 MHz gives 400 kHz.
- `TABLE_LEN`, 192: number of table entries, 1..1023.
- `DEV_ADDR`, 8'h60: sensor 8-bit write address.
- `PWR_WAIT`, 96000: clk cycles of settle time, 1 ms at 96 MHz.

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to run the table; sampled only in IDLE.
- `busy` out 1: high from the cycle after an accepted `start` until DONE.
- `done` out 1: one-cycle pulse when the last entry's STOP completes.
- `err` out 1: sticky NACK flag, cleared by `rst` or accepted `start`.
- `tbl_addr` out 10: table index.
- `tbl_data` in 16: `{reg[15:8], val[7:0]}`, valid one cycle after `tbl_addr` changes (synchronous ROM).
- `sio_c` out 1: SCCB clock.
- `sio_d_out` out 1: SCCB data drive value.
- `sio_d_oe` out 1: 1 = drive `sio_d_out`, 0 = release.
- `sio_d_in` in 1: sampled pad value.

## Operation
- States: IDLE → PWR → FETCH → START → SHIFT → STOP → GAP → (FETCH | SRST | DONE) → IDLE.
- **IDLE**: bus idle (`sio_c=1`, `sio_d_oe=1`, `sio_d_out=1`). On `start`: clear `err`, set `tbl_addr=0`, load the wait counter with PWR_WAIT, go to PWR.
- **PWR**: count down to 0, then go to FETCH.
- **FETCH**: one cycle for ROM latency. Latch `tbl_data` into a 27-bit shift register: `{DEV_ADDR, X, reg, X, val, X}`. Each X is the 9th (don't-care) bit, transmitted released.
- **START**: hold `sio_c=1`, `sio_d=0` for 2·CLK_DIV cycles, then go to SHIFT.
- **SHIFT**: 27 bits, MSB first. Each bit is quarters q0..q3: `sio_c` low on q0/q1 and high on q2/q3. `sio_d` changes only at the q0 boundary. `sio_d_oe=0` during the 9th bit of each phase. Bit counter runs 26→0.
- **STOP**: `sio_c=0`/`sio_d=0` for one quarter, then `sio_c=1` for one quarter, then `sio_d=1` for one quarter.
- **GAP**: bus idle for 4·CLK_DIV cycles.
- After GAP:
  - If the entry was reg 8'h12 with val[7]=1 (COM7 soft reset), go to SRST. SRST reloads PWR_WAIT, counts down, then proceeds as below.
  - If `tbl_addr == TABLE_LEN-1`, go to DONE.
  - Otherwise increment `tbl_addr` and go to FETCH.
- **DONE**: pulse `done`, drop `busy`, return to IDLE.
- `start` outside IDLE is ignored.
- `rst` mid-transaction returns to IDLE at the next edge with the bus released-high. The sensor then sees an incomplete frame, which it discards.
- `tbl_addr` never exceeds TABLE_LEN-1.

## Timing
- Reset values: `busy=0`, `done=0`, `err=0`, `tbl_addr=0`, `sio_c=1`, `sio_d_out=1`, `sio_d_oe=1`.
- `busy` rises 1 cycle after `start`. The first `sio_d` fall occurs PWR_WAIT+2 cycles after `start`.
- Per entry: 1 (FETCH) + 2·CLK_DIV (START) + 108·CLK_DIV (SHIFT) + 3·CLK_DIV (STOP) + 4·CLK_DIV (GAP) = 117·CLK_DIV+1 cycles.
- Total run time: PWR_WAIT + 1 + TABLE_LEN·(117·CLK_DIV+1) + (PWR_WAIT per soft reset).
- `done` is a single cycle; `busy` falls on the same edge that `done` rises.

## Configuration
- `SCCB_ACK_CHECK_EN` defined:
  - `sio_d_in` is sampled at the midpoint of q2 of each 9th bit.
  - A sampled 1 sets `err`. The transaction continues; no retry is performed.
- `SCCB_ACK_CHECK_EN` undefined: the 9th bit is fully don't-care, `sio_d_in` is unused, and `err` is tied to 0.

## Structure
- Shared package `cmos_pkg`: state enumeration, COM7 address 8'h12, SCCB frame length 27, default DEV_ADDR.
- One sub-module, `sccb_quarter_tick`: a CLK_DIV divider producing a quarter-bit strobe, enabled only in START/SHIFT/STOP/GAP. It restarts from 0 on enable to keep quarter boundaries aligned.

## Test plan
Bench settings: CLK_DIV=4, PWR_WAIT=16, TABLE_LEN=3, ROM = {16'h1280, 16'hFF01, 16'h1101}.
- **Reset then start**: `busy` rises at +1; the first `sio_d` fall is at +18. A bus model decodes writes 60/12/80, 60/FF/01, 60/11/01 in order.
- **Soft reset wait**: after the 60/12/80 STOP+GAP, the bus stays idle ≥16 cycles before the next START. Entry 2 (reg 8'h11) gets no extra wait.
- **Completion**:
  - `done` is one cycle, at the expected cycle count.
  - `busy` falls on the same edge `done` rises.
  - `tbl_addr` never exceeds 2.
  - A second `start` reruns the table identically.
- **Start while busy**: pulse `start` mid-SHIFT → no effect on bus trace or `tbl_addr`.
- **Reset mid-transaction**: assert `rst` during the second entry's SHIFT → next edge shows `sio_c=1`, `sio_d_out=1`, `busy=0`, `tbl_addr=0`.
- **NACK detection** (`SCCB_ACK_CHECK_EN`): slave model NACKs the reg phase of entry 1 → `err=1` sticky through `done`. All 3 writes are still emitted; `err` clears on the next `start`.
